// File: rtl/display_scan_ctrl_pkg.sv
// display_pkg: shared types and constants for the display scan controller.
//   scan_state_e : FSM states IDLE / BLANK / DRIVE
//   SEG_OFF      : all-segments-off value of the active-low {dp,g..a} bus
//   HEX_GLYPH    : active-low {g,f,e,d,c,b,a} glyphs for hex digits 0-F
//   bits_for()   : counter width for a terminal bound, minimum 1 bit
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  function automatic int unsigned bits_for(input int unsigned bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: bus between the counter datapath / board pins and the
// scan controller.
//   enable      : 1 = scan running, 0 = display dark
//   digit_data  : nibble i = hex value of digit i
//   blank_mask  : bit i = 1 -> digit i segments forced off
//   dp_mask     : bit i = 1 -> digit i decimal point lit
//   sel_code    : digit index to the 4-16 decoder
//   sel_en      : decoder enable
//   seg_n       : {dp,g,f,e,d,c,b,a}, active-low
//   frame_done  : 1-cycle pulse at end of the last digit's DRIVE
// master drives the inputs and observes the display pins; slave is the controller.
interface display_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 8
);

  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [3:0]              sel_code;
  logic                    sel_en;
  logic [7:0]              seg_n;
  logic                    frame_done;

  modport master (
    output enable, digit_data, blank_mask, dp_mask,
    input  sel_code, sel_en, seg_n, frame_done
  );

  modport slave (
    input  enable, digit_data, blank_mask, dp_mask,
    output sel_code, sel_en, seg_n, frame_done
  );

endinterface

// File: rtl/display_scan_ctrl_hex7seg.sv
// hex7seg: combinational hex nibble -> active-low 7-segment glyph.
//   value   : 4-bit hex digit
//   glyph_n : {g,f,e,d,c,b,a}, active-low
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] glyph_n
);

  always_comb begin
    glyph_n = HEX_GLYPH[value];
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for the counter display.
// Cycles a digit index, drives the digit-select decoder and the shared
// active-low 7-segment bus, with a blanking gap before every digit.
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active-low
//   bus   : display_scan_ctrl_if slave (enable, digit data/masks in;
//           sel_code, sel_en, seg_n, frame_done out)
// Every output is a register loaded from the current FSM state, so the pins
// follow the state by one cycle; enable=0 dark-gates them on the very next edge.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned DEAD_CYC   = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  display_scan_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = bits_for((DIV > DEAD_CYC) ? DIV : DEAD_CYC);
  localparam int unsigned IDX_W = bits_for(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_data_q, snap_data_d;
  logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [3:0]              sel_code_q, sel_code_d;
  logic                    sel_en_q, sel_en_d;
  logic [7:0]              seg_n_q, seg_n_d;
  logic                    frame_done_q, frame_done_d;

  logic                    load_snap;
  logic [3:0]              cur_nibble;
  logic                    cur_blank;
  logic                    cur_dp;
  logic [6:0]              glyph_n;

  // Current digit's fields, taken from the frame snapshot.
  always_comb begin
    cur_nibble = 4'(snap_data_q >> {idx_q, 2'b00});
    cur_blank  = snap_blank_q[idx_q];
    cur_dp     = snap_dp_q[idx_q];
  end

  hex7seg u_hex7seg (
    .value   (cur_nibble),
    .glyph_n (glyph_n)
  );

  // Next state, counters and snapshot.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    load_snap    = 1'b0;

    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = BLANK;
          cnt_d     = '0;
          idx_d     = '0;
          load_snap = 1'b1;
        end
        BLANK: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == DIV_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d        = '0;
              load_snap    = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    snap_data_d  = load_snap ? bus.digit_data : snap_data_q;
    snap_blank_d = load_snap ? bus.blank_mask : snap_blank_q;
    snap_dp_d    = load_snap ? bus.dp_mask    : snap_dp_q;
  end

  // Output register inputs, decoded from the current state.
  always_comb begin
    sel_code_d = '0;
    sel_en_d   = 1'b0;
    seg_n_d    = SEG_OFF;

    if (bus.enable) begin
      case (state_q)
        BLANK: begin
          sel_code_d = 4'(idx_q);
        end
        DRIVE: begin
          sel_code_d = 4'(idx_q);
          sel_en_d   = 1'b1;
          seg_n_d    = cur_blank ? SEG_OFF : {~cur_dp, glyph_n};
        end
        default: begin
          sel_code_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_data_q  <= '0;
      snap_blank_q <= '0;
      snap_dp_q    <= '0;
      sel_code_q   <= '0;
      sel_en_q     <= 1'b0;
      seg_n_q      <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_data_q  <= snap_data_d;
      snap_blank_q <= snap_blank_d;
      snap_dp_q    <= snap_dp_d;
      sel_code_q   <= sel_code_d;
      sel_en_q     <= sel_en_d;
      seg_n_q      <= seg_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.sel_code   = sel_code_q;
  assign bus.sel_en     = sel_en_q;
  assign bus.seg_n      = seg_n_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed bench for display_scan_ctrl with
// NUM_DIGITS=4, DIV=4, DEAD_CYC=1 (20-cycle frame). Outputs are sampled 1 time
// unit after each rising edge; each digit shows as one dark cycle with
// sel_code=k followed by four driven cycles, frame_done on the last of digit 3.
module tb_display_scan_ctrl;

  localparam int unsigned ND   = 4;
  localparam int unsigned DIV  = 4;
  localparam int unsigned DEAD = 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  display_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  display_scan_ctrl #(
    .NUM_DIGITS (ND),
    .DIV        (DIV),
    .DEAD_CYC   (DEAD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic en, input logic [3:0] code,
                               input logic [7:0] seg, input logic fd);
    check_val({tag, " sel_en"},     8'(bus.sel_en),     8'(en));
    check_val({tag, " sel_code"},   8'(bus.sel_code),   8'(code));
    check_val({tag, " seg_n"},      bus.seg_n,          seg);
    check_val({tag, " frame_done"}, 8'(bus.frame_done), 8'(fd));
  endtask

  // One digit slot: a dark cycle then DIV driven cycles. With mid_change set,
  // all inputs are cleared during the second driven cycle.
  task automatic check_digit(input int unsigned k, input logic [7:0] seg, input bit mid_change);
    tick();
    check_outputs($sformatf("d%0d blank", k), 1'b0, 4'(k), 8'hFF, 1'b0);
    for (int unsigned j = 0; j < DIV; j++) begin
      tick();
      check_outputs($sformatf("d%0d drive%0d", k, j), 1'b1, 4'(k), seg,
                    1'((k == ND - 1) && (j == DIV - 1)));
      if (mid_change && j == 1) begin
        bus.digit_data = '0;
        bus.blank_mask = '0;
        bus.dp_mask    = '0;
      end
    end
  endtask

  task automatic check_frame(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3, input int change_at);
    check_digit(0, s0, change_at == 0);
    check_digit(1, s1, change_at == 1);
    check_digit(2, s2, change_at == 2);
    check_digit(3, s3, change_at == 3);
  endtask

  initial begin
    bus.enable     = 1'b0;
    bus.digit_data = '0;
    bus.blank_mask = '0;
    bus.dp_mask    = '0;

    // Reset held, then released with enable low: display stays dark.
    #12;
    check_outputs("reset", 1'b0, 4'h0, 8'hFF, 1'b0);
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      check_outputs("idle", 1'b0, 4'h0, 8'hFF, 1'b0);
    end

    // Basic scan of 8A10.
    bus.digit_data = 16'h8A10;
    bus.enable     = 1'b1;
    tick();
    check_outputs("enable edge", 1'b0, 4'h0, 8'hFF, 1'b0);
    check_frame(8'hC0, 8'hF9, 8'h88, 8'h80, -1);

    // Masks applied after the snapshot edge: visible one frame later.
    bus.blank_mask = 4'b0100;
    bus.dp_mask    = 4'b0001;
    check_frame(8'hC0, 8'hF9, 8'h88, 8'h80, -1);
    check_frame(8'h40, 8'hF9, 8'hFF, 8'h80, -1);

    // Inputs cleared during digit1: no tearing, all zeros next frame.
    check_frame(8'h40, 8'hF9, 8'hFF, 8'h80, 1);
    check_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, -1);

    // Drop enable during digit2 DRIVE.
    check_digit(0, 8'hC0, 1'b0);
    check_digit(1, 8'hC0, 1'b0);
    tick();
    check_outputs("pre-drop blank", 1'b0, 4'h2, 8'hFF, 1'b0);
    repeat (2) begin
      tick();
      check_outputs("pre-drop drive", 1'b1, 4'h2, 8'hC0, 1'b0);
    end
    bus.enable     = 1'b0;
    bus.digit_data = 16'h8A10;
    repeat (24) begin
      tick();
      check_outputs("disabled", 1'b0, 4'h0, 8'hFF, 1'b0);
    end

    // Re-enable: restart at digit0 with a fresh snapshot.
    bus.enable = 1'b1;
    tick();
    check_outputs("re-enable edge", 1'b0, 4'h0, 8'hFF, 1'b0);
    check_frame(8'hC0, 8'hF9, 8'h88, 8'h80, -1);

    // Asynchronous reset mid-DRIVE of digit1.
    check_digit(0, 8'hC0, 1'b0);
    tick();
    check_outputs("pre-reset blank", 1'b0, 4'h1, 8'hFF, 1'b0);
    tick();
    check_outputs("pre-reset drive", 1'b1, 4'h1, 8'hF9, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check_outputs("async reset", 1'b0, 4'h0, 8'hFF, 1'b0);
    tick();
    check_outputs("reset held", 1'b0, 4'h0, 8'hFF, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_outputs("post-reset edge", 1'b0, 4'h0, 8'hFF, 1'b0);
    check_frame(8'hC0, 8'hF9, 8'h88, 8'h80, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
